// File: rtl/psum_pkg.sv
// Shared types, default parameters and the saturation helper for the
// partial-sum accumulation buffer.
package psum_pkg;

    localparam int DEF_DATA_W  = 25;
    localparam int DEF_NUM_PE  = 4;
    localparam int DEF_DEPTH   = 61;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_ADD_LAT = 3;

    localparam int SUM_W = DEF_DATA_W + $clog2(DEF_NUM_PE + 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ACC,
        DRAIN
    } state_t;

    // Clamp a wide signed value into the signed range of w bits.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/psum_adder_tree.sv
// Enable-gated saturating adder: sums NUM_PE PE outputs plus the buffered
// partial sum, then carries the result through ADD_LAT pipeline stages.
module psum_adder_tree
    import psum_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_PE  = DEF_NUM_PE,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int TAG_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [NUM_PE*DATA_W-1:0] in_pe,
    input  logic [DATA_W-1:0]        in_acc,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_sum,
    output logic                     out_ovf,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     pipe_busy
);

    localparam int SUM_W_L = DATA_W + $clog2(NUM_PE + 1);

    function automatic logic signed [SUM_W_L-1:0] sext(input logic [DATA_W-1:0] x);
        return {{(SUM_W_L - DATA_W){x[DATA_W-1]}}, x};
    endfunction

    logic signed [SUM_W_L-1:0] sum_full;
    logic signed [63:0]        sum_ext;
    logic signed [63:0]        sat_val;
    logic                      sat_ovf;

    // Full-precision sum cannot overflow; clamping happens once at the end.
    always_comb begin
        sum_full = sext(in_acc);
        for (int i = 0; i < NUM_PE; i++) begin
            sum_full = sum_full + sext(in_pe[i*DATA_W +: DATA_W]);
        end
        sum_ext = {{(64 - SUM_W_L){sum_full[SUM_W_L-1]}}, sum_full};
        sat_val = sat_to_width(sum_ext, DATA_W);
        sat_ovf = (sat_val != sum_ext);
    end

    logic [ADD_LAT-1:0] vld_vec;

    genvar gi;
    for (gi = 0; gi < ADD_LAT; gi++) begin : g_stage
        logic              vld_d;
        logic              vld_reg;
        logic              ovf_d;
        logic              ovf_reg;
        logic [DATA_W-1:0] sum_d;
        logic [DATA_W-1:0] sum_reg;
        logic [TAG_W-1:0]  tag_d;
        logic [TAG_W-1:0]  tag_reg;

        if (gi == 0) begin : g_head
            assign vld_d = in_valid;
            assign ovf_d = sat_ovf;
            assign sum_d = sat_val[DATA_W-1:0];
            assign tag_d = in_tag;
        end else begin : g_tail
            assign vld_d = g_stage[gi-1].vld_reg;
            assign ovf_d = g_stage[gi-1].ovf_reg;
            assign sum_d = g_stage[gi-1].sum_reg;
            assign tag_d = g_stage[gi-1].tag_reg;
        end

        // Flush only kills valid bits; stale data behind them is harmless.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_reg <= 1'b0;
                ovf_reg <= 1'b0;
                sum_reg <= '0;
                tag_reg <= '0;
            end else if (flush) begin
                vld_reg <= 1'b0;
            end else if (en) begin
                vld_reg <= vld_d;
                ovf_reg <= ovf_d;
                sum_reg <= sum_d;
                tag_reg <= tag_d;
            end
        end

        assign vld_vec[gi] = vld_reg;
    end

    assign out_valid = g_stage[ADD_LAT-1].vld_reg;
    assign out_sum   = g_stage[ADD_LAT-1].sum_reg;
    assign out_ovf   = g_stage[ADD_LAT-1].ovf_reg;
    assign out_tag   = g_stage[ADD_LAT-1].tag_reg;
    assign pipe_busy = |vld_vec;

endmodule

// File: rtl/psum_accum_buff.sv
// Partial-sum row buffer: accumulates PE beats per column across passes and
// streams the final pass through a valid/ready port with saturation tracking.
module psum_accum_buff
    import psum_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_PE  = DEF_NUM_PE,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_start,
    input  logic [ADDR_W-1:0]        cfg_row_len,
    input  logic                     cfg_abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err_cfg,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [NUM_PE*DATA_W-1:0] pe_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     ovf_sticky
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t state_reg;
    state_t state_next;

    logic [ADDR_W-1:0] row_len_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] col_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              ovf_sticky_reg;
    logic              done_reg;
    logic              err_cfg_reg;

    logic [DATA_W-1:0] buf_mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              buf_we;
    logic [DATA_W-1:0] buf_wdata;

    logic              pipe_en;
    logic              handshake;
    logic              accept;
    logic              col_is_last;
    logic              cfg_ok;
    logic              init_end;
    logic              drain_end;
    logic              res_take;
    logic              wb_en;
    logic              out_load;

    logic              p_valid;
    logic              p_ovf;
    logic              p_busy;
    logic [DATA_W-1:0] p_sum;
    logic [1:0]        p_tag;

    assign pipe_en     = !(out_valid_reg && !out_ready);
    assign handshake   = out_valid_reg && out_ready;
    assign accept      = (state_reg == ACC) && in_valid && pipe_en;
    assign col_is_last = (col_reg == row_len_reg - ONE);
    assign cfg_ok      = (cfg_row_len != '0)
                      && (cfg_row_len <= ADDR_W'(DEPTH))
                      && (cfg_row_len >  ADDR_W'(ADD_LAT));
    assign init_end    = (state_reg == INIT) && (wr_ptr_reg == row_len_reg - ONE);
    assign drain_end   = handshake && out_last_reg && !p_busy;

    // Tag bit 1 = beat of the final pass, bit 0 = last column of the row.
    assign res_take = pipe_en && p_valid;
    assign wb_en    = res_take && !p_tag[1];
    assign out_load = res_take && p_tag[1];

    assign rd_data   = buf_mem[rd_ptr_reg[IDX_W-1:0]];
    assign buf_we    = (state_reg == INIT) || wb_en;
    assign buf_wdata = (state_reg == INIT) ? '0 : p_sum;

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_ptr_reg[IDX_W-1:0]] <= buf_wdata;
        end
    end

    psum_adder_tree #(
        .DATA_W  (DATA_W),
        .NUM_PE  (NUM_PE),
        .ADD_LAT (ADD_LAT),
        .TAG_W   (2)
    ) u_adder (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pipe_en),
        .flush     (cfg_abort),
        .in_valid  (accept),
        .in_pe     (pe_data),
        .in_acc    (rd_data),
        .in_tag    ({in_last, col_is_last}),
        .out_valid (p_valid),
        .out_sum   (p_sum),
        .out_ovf   (p_ovf),
        .out_tag   (p_tag),
        .pipe_busy (p_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (cfg_abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (cfg_start && cfg_ok) state_next = INIT;
                INIT:    if (init_end) state_next = ACC;
                ACC:     if (accept && in_last && col_is_last) state_next = DRAIN;
                DRAIN:   if (drain_end) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        in_ready = (state_reg == ACC) && pipe_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_len_reg    <= '0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            col_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_data_reg   <= '0;
            ovf_sticky_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_cfg_reg    <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            err_cfg_reg <= 1'b0;
            if (cfg_abort) begin
                rd_ptr_reg    <= '0;
                wr_ptr_reg    <= '0;
                col_reg       <= '0;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (cfg_start) begin
                            if (cfg_ok) begin
                                row_len_reg    <= cfg_row_len;
                                ovf_sticky_reg <= 1'b0;
                                rd_ptr_reg     <= '0;
                                wr_ptr_reg     <= '0;
                                col_reg        <= '0;
                            end else begin
                                err_cfg_reg <= 1'b1;
                            end
                        end
                    end
                    INIT: begin
                        wr_ptr_reg <= init_end ? '0 : wr_ptr_reg + ONE;
                    end
                    default: begin
                        if (accept) begin
                            rd_ptr_reg <= (rd_ptr_reg == row_len_reg - ONE) ? '0 : rd_ptr_reg + ONE;
                            col_reg    <= col_is_last ? '0 : col_reg + ONE;
                        end
                        if (wb_en) begin
                            wr_ptr_reg <= (wr_ptr_reg == row_len_reg - ONE) ? '0 : wr_ptr_reg + ONE;
                        end
                        if (state_reg == DRAIN && drain_end) begin
                            done_reg <= 1'b1;
                        end
                    end
                endcase

                // A fresh result may replace the one handshaking this cycle.
                if (out_load) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= p_sum;
                    out_last_reg  <= p_tag[0];
                end else if (handshake) begin
                    out_valid_reg <= 1'b0;
                end

                if (res_take && p_ovf) begin
                    ovf_sticky_reg <= 1'b1;
                end
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_last   = out_last_reg;
    assign ovf_sticky = ovf_sticky_reg;
    assign done       = done_reg;
    assign err_cfg    = err_cfg_reg;

endmodule

// File: doc/psum_accum_buff.md
Name: psum_accum_buff

Overview:
- Parametrised partial-sum accumulation buffer for the conv kernel. Sits between the PE array and write-back.
- Holds one output row of partial sums in a circular buffer. Each accepted beat adds NUM_PE PE outputs to the buffered value for that column and writes the result back.
- On the final pass, results stream out through a valid/ready port instead of being written back.
- Adds over the previous generation: NUM_PE generalisation, runtime row length, saturation with a sticky overflow flag, output backpressure, abort, and config error detection.

Parameters:
- DATA_W, 25, width of PE operands, stored sums and output.
- NUM_PE, 4, number of PE inputs summed per beat (1..16).
- DEPTH, 61, maximum row length (buffer entries).
- ADDR_W, 8, pointer/counter width; must satisfy 2^ADDR_W > DEPTH.
- ADD_LAT, 3, adder pipeline depth in enabled cycles (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  pulse; start a row using cfg_row_len
- cfg_row_len  in  ADDR_W  entries in this row
- cfg_abort  in  1  synchronous flush to IDLE
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last output beat handshakes
- err_cfg  out  1  one-cycle pulse on an illegal cfg_start
- in_valid  in  1  PE beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  beat belongs to the final pass; held constant for a whole pass
- pe_data  in  NUM_PE*DATA_W  packed signed PE outputs, PE0 in LSBs
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_W  final signed sum
- out_last  out  1  marks the last column of the row
- ovf_sticky  out  1  set on any saturation; cleared by cfg_start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all pointers, counters and pipe-valid bits are 0.
  - busy, done, err_cfg, in_ready, out_valid, out_last, ovf_sticky = 0; out_data = 0.
  - Buffer contents are don't-care.
  - Reset mid-operation discards everything; no done is produced.
- States: IDLE, INIT, ACC, DRAIN.
- IDLE:
  - cfg_start with 0 < cfg_row_len <= DEPTH and cfg_row_len > ADD_LAT: latch row_len, clear ovf_sticky, go to INIT.
  - Otherwise err_cfg pulses next cycle and the state stays IDLE.
  - cfg_start while busy is ignored.
- INIT:
  - Writes row_len zeros, one per cycle, at wr_ptr; in_ready=0.
  - After row_len cycles go to ACC with rd_ptr=wr_ptr=0 and col=0.
- ACC:
  - in_ready = pipe_en, where pipe_en = !(out_valid && !out_ready).
  - Accepted beat: read buffer[rd_ptr], rd_ptr++, col++ (wrapping at row_len).
  - Beat enters the adder pipeline. After ADD_LAT enabled cycles the result is:
    - in_last=0: written to buffer[wr_ptr], wr_ptr++ (wrap at row_len).
    - in_last=1: loaded into the output register; out_valid=1, out_last=(col==row_len-1).
  - Accepting a beat with in_last=1 and col==row_len-1 moves to DRAIN and drops in_ready.
- DRAIN: when the pipeline is empty and the final out_last beat handshakes, pulse done and go to IDLE.
- Pipeline stall: when pipe_en=0 every adder stage and the write-back hold. The read-modify-write distance of row_len > ADD_LAT guarantees a column is read only after its previous pass has been written back.
- Arithmetic:
  - Sum of NUM_PE+1 signed DATA_W terms, computed at DATA_W+clog2(NUM_PE+1) bits.
  - Saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Any clamp sets ovf_sticky.
- Output handshake: out_data/out_last are stable while out_valid && !out_ready. out_valid clears on handshake unless a new result loads in the same cycle.
- cfg_abort (any state): next cycle state=IDLE; pipe-valid bits, out_valid and pointers cleared; no done. cfg_abort beats cfg_start in the same cycle.
- in_valid outside ACC is ignored.

Decomposition:
- Package psum_pkg:
  - state enum {IDLE, INIT, ACC, DRAIN}
  - localparam SUM_W = DATA_W+$clog2(NUM_PE+1)
  - sat_to_width function
  - default parameter constants
- Sub-module psum_adder_tree: pipelined, enable-gated, saturating adder over NUM_PE+1 operands with ADD_LAT stages. It outputs the result, a valid bit and an ovf bit.
- The buffer is an inline register array.

Test Plan:
- Rows of 8 entries, NUM_PE=4, pe_data={1,2,3,4} on every beat, 3 passes with the last pass in_last=1:
  - expect 8 outputs of 30, out_last on the 8th, then done.
  - ovf_sticky stays 0.
- Max-positive pe_data for 2 passes at DATA_W=25: expect out_data=16777215 and ovf_sticky=1. A later cfg_start clears ovf_sticky.
- out_ready toggling 0/1 every 2 cycles during the final pass of a 10-entry row:
  - no loss or duplication; outputs in column order.
  - in_ready low exactly while out_valid && !out_ready.
- cfg_row_len=0, then DEPTH+1, then ADD_LAT: err_cfg pulses each time; busy stays 0.
- cfg_abort mid-ACC on pass 2: busy=0 next cycle and no done. A fresh row of 5 then yields the correct sums (buffer re-zeroed by INIT).
- rst_n low for 1 cycle during DRAIN: all outputs are 0 immediately. The next row runs correctly.
